sub_serial_4: RTL and testbench



---
 rtl/sub_serial_4.sv | 84 ++++++++
 tb/tb_sub_serial_4.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sub_serial_4.sv
// sub_serial_4: serial WIDTH-bit subtractor, D = A_in - B_in - B_1, one 4-bit slice per clock, LSB slice first
// Ports: clk/rst_n (async active-low); in_valid/in_ready accept A_in, B_in, B_1 in IDLE;
//        out_valid/out_ready hand over D (difference mod 2^WIDTH) and BO (borrow-out); busy high in RUN or DONE
module sub_serial_4 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  input  logic             B_1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             BO,
  output logic             busy
);
  localparam int N  = WIDTH / 4;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, d_q, d_d;
  logic             borrow_q, borrow_d, bo_q, bo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [4:0]       diff;
  always_comb begin
    // bit 4 of the 5-bit slice difference is the borrow into the next slice
    diff     = {1'b0, a_q[4*int'(cnt_q) +: 4]} - {1'b0, b_q[4*int'(cnt_q) +: 4]} - {4'b0, borrow_q};
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    d_d      = d_q;
    borrow_d = borrow_q;
    bo_d     = bo_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d  = RUN;
        a_d      = A_in;
        b_d      = B_in;
        borrow_d = B_1;
        cnt_d    = '0;
      end
      RUN: begin
        d_d[4*int'(cnt_q) +: 4] = diff[3:0];
        borrow_d = diff[4];
        if (cnt_q == CW'(N - 1)) begin
          bo_d    = diff[4];
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      d_q      <= '0;
      borrow_q <= 1'b0;
      bo_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      d_q      <= d_d;
      borrow_q <= borrow_d;
      bo_q     <= bo_d;
      cnt_q    <= cnt_d;
    end
  end
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign D         = d_q;
  assign BO        = bo_q;
endmodule

// File: tb/tb_sub_serial_4.sv
// tb_sub_serial_4: scoreboard bench for sub_serial_4 at WIDTH=16 and WIDTH=4
module tb_sub_serial_4;
  logic clk = 0, rst_n = 0;
  logic iv16 = 0, ir16, b116 = 0, ov16, ordy16 = 1, bo16, busy16;
  logic [15:0] a16 = 0, b16 = 0, d16;
  logic iv4 = 0, ir4, b14 = 0, ov4, ordy4 = 1, bo4, busy4;
  logic [3:0] a4 = 0, b4 = 0, d4;
  int vectors = 0, miss = 0, cyc = 0;
  int acc16_n = 0, res16_n = 0, acc4_n = 0, res4_n = 0;
  bit rnd = 0;
  logic [16:0] q16[$];
  logic [4:0] q4[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sub_serial_4 #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .A_in(a16), .B_in(b16), .B_1(b116),
    .out_valid(ov16), .out_ready(ordy16), .D(d16), .BO(bo16), .busy(busy16));
  sub_serial_4 #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .A_in(a4), .B_in(b4), .B_1(b14),
    .out_valid(ov4), .out_ready(ordy4), .D(d4), .BO(bo4), .busy(busy4));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // present one operation, push the reference result on acceptance
  task automatic send(input int w, input logic [15:0] av, input logic [15:0] bv, input logic b1v,
                      input bit keep, output int acc);
    int n = 0;
    logic [16:0] f;
    logic [4:0] g;
    @(posedge clk); #1;
    if (w == 16) begin iv16 = 1; a16 = av; b16 = bv; b116 = b1v; end
    else begin iv4 = 1; a4 = av[3:0]; b4 = bv[3:0]; b14 = b1v; end
    forever begin
      @(negedge clk);
      if (w == 16 ? ir16 : ir4) break;
      if (++n > 100) break;
    end
    if (n > 100) begin
      vectors++; miss++; acc = -1;
      $display("FAIL accept_timeout%0d: got in_ready=0, expected 1", w);
    end else begin
      acc = cyc + 1;
      if (w == 16) begin
        f = {1'b0, av} - {1'b0, bv} - 17'(b1v);
        q16.push_back(f); acc16_n++;
      end else begin
        g = {1'b0, av[3:0]} - {1'b0, bv[3:0]} - 5'(b1v);
        q4.push_back(g); acc4_n++;
      end
    end
    @(posedge clk); #1;
    if (!keep) begin if (w == 16) iv16 = 0; else iv4 = 0; end
  endtask

  task automatic wait_ov(input int w, input int acc, input int lat);
    int n = 0;
    forever begin
      @(negedge clk);
      if (w == 16 ? ov16 : ov4) break;
      if (++n > 50) break;
    end
    chk(w == 16 ? "latency16" : "latency4", cyc - acc, lat);
  endtask

  logic p_ov16 = 0, p_take16 = 0, p_ov4 = 0, p_take4 = 0;
  logic [16:0] p_val16;
  logic [4:0] p_val4;

  always @(negedge clk) begin
    if (!rst_n) begin
      p_ov16 <= 0; p_take16 <= 0;
    end else begin
      if (p_ov16 && !p_take16 && ov16) chk("hold16", {bo16, d16}, p_val16);
      if (ov16) chk("in_ready_done16", ir16, 0);
      if (ov16 && ordy16) begin
        res16_n++;
        if (q16.size() == 0) begin
          vectors++; miss++;
          $display("FAIL extra_result16: got %0h, expected no result", {bo16, d16});
        end else chk("result16", {bo16, d16}, q16.pop_front());
      end
      p_ov16 <= ov16; p_take16 <= ov16 && ordy16; p_val16 <= {bo16, d16};
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      p_ov4 <= 0; p_take4 <= 0;
    end else begin
      if (p_ov4 && !p_take4 && ov4) chk("hold4", {bo4, d4}, p_val4);
      if (ov4 && ordy4) begin
        res4_n++;
        if (q4.size() == 0) begin
          vectors++; miss++;
          $display("FAIL extra_result4: got %0h, expected no result", {bo4, d4});
        end else chk("result4", {bo4, d4}, q4.pop_front());
      end
      p_ov4 <= ov4; p_take4 <= ov4 && ordy4; p_val4 <= {bo4, d4};
    end
  end

  always @(posedge clk) if (rnd) begin
    #1;
    ordy16 = ($urandom_range(0, 3) != 0);
    ordy4  = ($urandom_range(0, 2) != 0);
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acc, acc1, acc2, acc3, ra, rb;
    @(negedge clk);
    chk("rst_in_ready", ir16, 1);
    chk("rst_out_valid", ov16, 0);
    chk("rst_busy", busy16, 0);
    chk("rst_D", d16, 0);
    chk("rst_BO", bo16, 0);
    chk("rst_in_ready4", ir4, 1);
    #2 rst_n = 1;

    send(16, 16'h1234, 16'h0235, 0, 0, acc); wait_ov(16, acc, 4);
    chk("busy_done", busy16, 1);
    send(16, 16'h0000, 16'h0001, 0, 0, acc); wait_ov(16, acc, 4);
    send(16, 16'h8000, 16'h7FFF, 1, 0, acc); wait_ov(16, acc, 4);
    send(4, 16'h9, 16'hC, 1, 0, acc); wait_ov(4, acc, 1);

    @(posedge clk); #1; ordy16 = 0;
    send(16, 16'($urandom), 16'($urandom), 1, 0, acc); wait_ov(16, acc, 4);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      iv16 = (i % 2 == 0); a16 = 16'($urandom); b16 = 16'($urandom);
      @(negedge clk);
      chk("bp_out_valid", ov16, 1);
      chk("bp_in_ready", ir16, 0);
    end
    @(posedge clk); #1; iv16 = 0; ordy16 = 1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_out_valid", ov16, 0);
    chk("bp_release_in_ready", ir16, 1);

    send(16, 16'($urandom), 16'($urandom), 0, 1, acc1);
    send(16, 16'($urandom), 16'($urandom), 1, 1, acc2);
    send(16, 16'($urandom), 16'($urandom), 0, 0, acc3);
    chk("b2b_gap1", acc2 - acc1, 6);
    chk("b2b_gap2", acc3 - acc2, 6);
    wait_ov(16, acc3, 4);

    send(16, 16'hABCD, 16'h1357, 1, 0, acc);
    @(posedge clk); @(posedge clk); #2;
    rst_n = 0;
    #1;
    chk("abort_in_ready", ir16, 1);
    chk("abort_out_valid", ov16, 0);
    chk("abort_busy", busy16, 0);
    chk("abort_D", d16, 0);
    chk("abort_BO", bo16, 0);
    q16.delete();
    @(negedge clk); #1 rst_n = 1;
    send(16, 16'd5, 16'd3, 0, 0, acc); wait_ov(16, acc, 4);

    @(posedge clk); #1;
    acc16_n = 0; res16_n = 0; acc4_n = 0; res4_n = 0; rnd = 1;
    fork
      for (int i = 0; i < 1000; i++) begin
        send(16, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 0, ra);
        repeat ($urandom_range(0, 2)) @(posedge clk);
      end
      for (int j = 0; j < 1000; j++) begin
        send(4, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 0, rb);
        repeat ($urandom_range(0, 2)) @(posedge clk);
      end
    join
    for (int n = 0; n < 100 && (q16.size() != 0 || q4.size() != 0); n++) @(posedge clk);
    rnd = 0;
    @(posedge clk); #1; ordy16 = 1; ordy4 = 1;
    @(negedge clk);
    chk("lost16", q16.size(), 0);
    chk("lost4", q4.size(), 0);
    chk("count16", res16_n, acc16_n);
    chk("count4", res4_n, acc4_n);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule
